my_byte_assembler: RTL and testbench
====================================

# my_byte_assembler

Serial-to-parallel front end for the 8-way OR reduction stage. It accepts one bit per handshake and assembles eight bits into a byte. It then presents the byte on an 8-bit bus, held stable until the downstream consumer (the 8-way OR and anything sharing its bus) accepts it. Valid/ready handshakes on both sides give flow control and backpressure with no data loss.

## Interface
Parameters:
- MSB_FIRST, 1, bit order. 1: first accepted bit lands in word_out[7]. 0: first accepted bit lands in word_out[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  block can accept a bit this cycle
- word_out  output  8  assembled byte; meaningful only while word_valid=1
- word_valid  output  1  word_out holds a complete byte
- word_ready  input  1  consumer accepts word_out this cycle
- count  output  4  bits accepted into the current byte, 0..8

## Operation
- Two states: FILL and HOLD.
- Reset (reset=1 at a rising edge):
  - state=FILL, shift register=8'h00, count=0.
  - Resulting outputs: word_out=8'h00, word_valid=0, bit_ready=1.
  - All other inputs are ignored on that edge; an in-progress byte or a held byte is discarded.
- Output decode:
  - bit_ready = (state==FILL).
  - word_valid = (state==HOLD).
  - word_out is the shift register, driven directly with no extra output register.
- FILL:
  - A bit is accepted on an edge where bit_valid & bit_ready.
  - MSB_FIRST=1: shreg <= {shreg[6:0], bit_in}.
  - MSB_FIRST=0: shreg <= {bit_in, shreg[7:1]}.
  - Each acceptance increments count.
  - When the accepted bit is the 8th (count was 7), count becomes 8 and state becomes HOLD.
  - bit_valid=0 leaves all state unchanged; gaps of any length are allowed.
- HOLD:
  - word_out and count (=8) stay frozen. bit_ready=0, and bit_in/bit_valid are ignored.
  - On an edge with word_valid & word_ready, state becomes FILL, count becomes 0 and shreg becomes 8'h00.
  - word_ready=0 holds indefinitely.
- word_ready sampled while in FILL has no effect.
- count never exceeds 8 and never wraps.

## Timing
- Byte latency: the edge that accepts the 8th bit sets word_valid=1 in the following cycle.
- Handoff: the edge where word_valid & word_ready sets word_valid=0 and bit_ready=1 in the following cycle.
- No bit is accepted on the handoff edge, so there is a one-cycle bubble.
- Sustained throughput: 1 byte per 9 cycles with bit_valid and word_ready held high.
- Reset while word_valid=1 and word_ready=1 on the same edge: reset wins. The word is dropped; the consumer must not count it as delivered.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.

## Test plan
- Reset then idle: assert reset for 2 cycles, then hold bit_valid=0 for 5 cycles. Required: word_out=8'h00, word_valid=0, bit_ready=1, count=0 throughout.
- MSB-first byte: MSB_FIRST=1, bits 0,0,0,1,0,1,1,1 on consecutive cycles, word_ready=1. Required:
  - word_valid=1 for exactly one cycle with word_out=8'h17, count=8.
  - Then bit_ready=1, count=0.
  - The downstream 8-way OR output is 1.
- LSB-first byte with gaps: MSB_FIRST=0, same bit sequence with bit_valid low every other cycle. Required: word_out=8'hE8 after the 8th accepted bit; count advances only on valid cycles.
- Backpressure: after a byte of all 1s, hold word_ready=0 for 5 cycles while driving bit_valid=1, bit_in=0. Required:
  - word_out stays 8'hFF, bit_ready=0, count=8 through the stall.
  - Raising word_ready hands off on the next edge.
- Zero byte: eight 0 bits. Required: word_valid=1 with word_out=8'h00; the downstream 8-way OR output is 0.
- Reset mid-operation:
  - Assert reset after 5 accepted bits. Required: count=0, word_out=8'h00 on the next cycle; the next 8 bits form a fresh byte.
  - Assert reset while in HOLD with word_ready=1 on the same edge. Required: word_valid=0 and no handoff.

Source files
------------

// File: rtl/my_byte_assembler.sv
// my_byte_assembler
//   Serial-to-parallel front end. Accepts one bit per bit handshake and
//   assembles eight of them into a byte. The byte is then held on word_out
//   until the consumer takes it.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. The producer may change its data whenever
//   valid=0. This block never lowers word_valid or changes word_out before a
//   transfer. bit_ready and word_valid depend only on registered state, so
//   neither depends on the same-cycle inputs.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is valid this cycle
//   bit_ready  out  block can accept a bit (state FILL)
//   word_out   out  8-bit assembled byte (shift register, driven directly)
//   word_valid out  word_out holds a complete byte (state HOLD)
//   word_ready in   consumer accepts word_out this cycle
//   count      out  bits accepted into the current byte, 0..8
//
// Parameter:
//   MSB_FIRST  1: the first accepted bit ends up in word_out[7]
//              0: the first accepted bit ends up in word_out[0]
module my_byte_assembler #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] word_out,
  output logic       word_valid,
  input  logic       word_ready,
  output logic [3:0] count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] count_q, count_d;

  logic bit_fire;
  logic word_fire;

  assign bit_fire  = (state_q == FILL) && bit_valid;
  assign word_fire = (state_q == HOLD) && word_ready;

  // State register. Reset takes priority over any handoff on the same edge,
  // so a byte presented while reset is high is never delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      shreg_q <= 8'h00;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  // Next-state logic, covering both the FSM and the datapath.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (bit_fire) begin
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[6:0], bit_in};
          end else begin
            shreg_d = {bit_in, shreg_q[7:1]};
          end
          count_d = count_q + 4'd1;
          // The 8th bit (count was 7) completes the byte.
          if (count_q == 4'd7) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // The handoff edge clears the register and accepts no bit.
        // This leaves a one-cycle bubble before the next byte.
        if (word_fire) begin
          state_d = FILL;
          shreg_d = 8'h00;
          count_d = 4'd0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Output decode, from registered state only.
  always_comb begin
    bit_ready  = (state_q == FILL);
    word_valid = (state_q == HOLD);
    word_out   = shreg_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_my_byte_assembler.sv
module tb_my_byte_assembler;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       word_ready;

  logic       bit_ready_m, word_valid_m;
  logic [7:0] word_out_m;
  logic [3:0] count_m;
  logic       bit_ready_l, word_valid_l;
  logic [7:0] word_out_l;
  logic [3:0] count_l;

  int checks = 0;
  int errors = 0;

  my_byte_assembler #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_m), .word_out(word_out_m), .word_valid(word_valid_m),
    .word_ready(word_ready), .count(count_m)
  );

  my_byte_assembler #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_l), .word_out(word_out_l), .word_valid(word_valid_l),
    .word_ready(word_ready), .count(count_l)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge. Outputs are sampled at
  // that same point, after they have settled from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; word_ready = 1'b0;
    step();
    step();
    reset = 1'b0; bit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (word_out_m !== 8'h00 || word_valid_m !== 1'b0 || bit_ready_m !== 1'b1 || count_m !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle_m: got out=%h v=%b r=%b c=%0d expected out=00 v=0 r=1 c=0",
                 word_out_m, word_valid_m, bit_ready_m, count_m);
      end
      checks++;
      if (word_out_l !== 8'h00 || word_valid_l !== 1'b0 || bit_ready_l !== 1'b1 || count_l !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle_l: got out=%h v=%b r=%b c=%0d expected out=00 v=0 r=1 c=0",
                 word_out_l, word_valid_l, bit_ready_l, count_l);
      end
    end
  endtask

  task automatic test_msb_byte();
    logic [7:0] bits;
    bits = 8'b0001_0111;  // sent as bits[7] first: 0,0,0,1,0,1,1,1
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = bits[7-i];
      step();
      checks++;
      if (count_m !== 4'(i + 1)) begin
        errors++;
        $display("FAIL msb_count: got %0d expected %0d", count_m, i + 1);
      end
      if (i < 7) begin
        checks++;
        if (word_valid_m !== 1'b0) begin
          errors++;
          $display("FAIL msb_early_valid: got %b expected 0 at bit %0d", word_valid_m, i);
        end
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (word_valid_m !== 1'b1 || word_out_m !== 8'h17 || count_m !== 4'd8 || bit_ready_m !== 1'b0) begin
      errors++;
      $display("FAIL msb_word: got v=%b out=%h c=%0d r=%b expected v=1 out=17 c=8 r=0",
               word_valid_m, word_out_m, count_m, bit_ready_m);
    end
    checks++;
    if ((|word_out_m) !== 1'b1) begin
      errors++;
      $display("FAIL msb_or: got %b expected 1", |word_out_m);
    end
    checks++;
    if (word_out_l !== 8'hE8) begin
      errors++;
      $display("FAIL lsb_mirror: got %h expected e8", word_out_l);
    end
    step();  // handoff edge
    checks++;
    if (word_valid_m !== 1'b0 || bit_ready_m !== 1'b1 || count_m !== 4'd0 || word_out_m !== 8'h00) begin
      errors++;
      $display("FAIL msb_handoff: got v=%b r=%b c=%0d out=%h expected v=0 r=1 c=0 out=00",
               word_valid_m, bit_ready_m, count_m, word_out_m);
    end
  endtask

  task automatic test_lsb_gaps();
    logic [7:0] bits;
    bits = 8'b0001_0111;
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b0; bit_in = ~bits[7-i];  // junk bit on a gap cycle
      step();
      checks++;
      if (count_l !== 4'(i)) begin
        errors++;
        $display("FAIL lsb_gap_count: got %0d expected %0d", count_l, i);
      end
      bit_valid = 1'b1; bit_in = bits[7-i];
      step();
      checks++;
      if (count_l !== 4'(i + 1)) begin
        errors++;
        $display("FAIL lsb_count: got %0d expected %0d", count_l, i + 1);
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (word_valid_l !== 1'b1 || word_out_l !== 8'hE8) begin
      errors++;
      $display("FAIL lsb_word: got v=%b out=%h expected v=1 out=e8", word_valid_l, word_out_l);
    end
    checks++;
    if (word_out_m !== 8'h17) begin
      errors++;
      $display("FAIL msb_mirror: got %h expected 17", word_out_m);
    end
    word_ready = 1'b1;
    step();
    checks++;
    if (word_valid_l !== 1'b0 || count_l !== 4'd0 || bit_ready_l !== 1'b1) begin
      errors++;
      $display("FAIL lsb_handoff: got v=%b c=%0d r=%b expected v=0 c=0 r=1",
               word_valid_l, count_l, bit_ready_l);
    end
  endtask

  task automatic test_backpressure();
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
    end
    bit_in = 1'b0;  // bit_valid stays high: these bits must be ignored
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (word_out_m !== 8'hFF || word_out_l !== 8'hFF || bit_ready_m !== 1'b0 ||
          count_m !== 4'd8 || word_valid_m !== 1'b1) begin
        errors++;
        $display("FAIL stall: got out=%h/%h r=%b c=%0d v=%b expected out=ff/ff r=0 c=8 v=1",
                 word_out_m, word_out_l, bit_ready_m, count_m, word_valid_m);
      end
    end
    bit_valid = 1'b0; word_ready = 1'b1;
    step();
    checks++;
    if (word_valid_m !== 1'b0 || bit_ready_m !== 1'b1 || count_m !== 4'd0) begin
      errors++;
      $display("FAIL stall_release: got v=%b r=%b c=%0d expected v=0 r=1 c=0",
               word_valid_m, bit_ready_m, count_m);
    end
  endtask

  task automatic test_zero_byte();
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b0;
      step();
    end
    bit_valid = 1'b0;
    checks++;
    if (word_valid_m !== 1'b1 || word_out_m !== 8'h00 || word_out_l !== 8'h00) begin
      errors++;
      $display("FAIL zero_word: got v=%b out=%h/%h expected v=1 out=00/00",
               word_valid_m, word_out_m, word_out_l);
    end
    checks++;
    if ((|word_out_m) !== 1'b0) begin
      errors++;
      $display("FAIL zero_or: got %b expected 0", |word_out_m);
    end
    word_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] bits;
    word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
    end
    checks++;
    if (count_m !== 4'd5) begin
      errors++;
      $display("FAIL mid_count: got %0d expected 5", count_m);
    end
    reset = 1'b1;  // bit_valid stays high: reset must win
    step();
    reset = 1'b0;
    checks++;
    if (count_m !== 4'd0 || word_out_m !== 8'h00 || count_l !== 4'd0 || word_out_l !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got c=%0d out=%h c_l=%0d out_l=%h expected 0/00 0/00",
               count_m, word_out_m, count_l, word_out_l);
    end
    bits = 8'b1100_1010;  // sent as 1,1,0,0,1,0,1,0
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = bits[7-i];
      step();
    end
    bit_valid = 1'b0;
    checks++;
    if (word_valid_m !== 1'b1 || word_out_m !== 8'hCA || word_out_l !== 8'h53) begin
      errors++;
      $display("FAIL fresh_byte: got v=%b out=%h/%h expected v=1 out=ca/53",
               word_valid_m, word_out_m, word_out_l);
    end
    // A reset and a handoff on the same edge: reset wins and the word is dropped.
    reset = 1'b1; word_ready = 1'b1;
    step();
    reset = 1'b0; word_ready = 1'b0;
    checks++;
    if (word_valid_m !== 1'b0 || bit_ready_m !== 1'b1 || count_m !== 4'd0 || word_out_m !== 8'h00) begin
      errors++;
      $display("FAIL hold_reset: got v=%b r=%b c=%0d out=%h expected v=0 r=1 c=0 out=00",
               word_valid_m, bit_ready_m, count_m, word_out_m);
    end
  endtask

  task automatic test_back_to_back();
    // With bit_valid and word_ready high, a byte completes every 9 cycles:
    // word_valid is set after edges 8 and 17.
    bit_valid = 1'b1; bit_in = 1'b1; word_ready = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      checks++;
      if (word_valid_m !== ((k == 8) || (k == 17))) begin
        errors++;
        $display("FAIL b2b_valid: got %b expected %b at cycle %0d",
                 word_valid_m, (k == 8) || (k == 17), k);
      end
    end
    bit_valid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
    test_reset();
    test_msb_byte();
    test_lsb_gaps();
    test_backpressure();
    test_zero_byte();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
